// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared CPU control encodings for operand-B selection
package cpu_ctrl_pkg;

    // Operand-B source select encodings shared by decode and execute
    typedef enum logic [2:0] {
        SEL_REGB  = 3'b000,
        SEL_INC   = 3'b001,
        SEL_BR    = 3'b010,
        SEL_SEXT  = 3'b011,
        SEL_ZEXT  = 3'b100,
        SEL_LUI   = 3'b101,
        SEL_SHAMT = 3'b110,
        SEL_RSVD  = 3'b111
    } opb_sel_e;

    // Shift-amount field position inside the immediate
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;

    // Branch offsets are word-aligned
    localparam int BR_SHIFT  = 2;

endpackage

// File: rtl/opb_skid_buffer.sv
// rtl/opb_skid_buffer.sv - two-entry registered skid buffer for the operand-B stage
module opb_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_s_tready;

    logic              w_s_xfer;
    logic              w_main_free;
    logic              w_main_valid_n;
    logic [DATA_W-1:0] w_main_data_n;
    logic              w_skid_valid_n;
    logic [DATA_W-1:0] w_skid_data_n;

    assign w_s_xfer    = s_tvalid & r_s_tready;
    // The main entry can take new data if it is empty or being drained this cycle
    assign w_main_free = ~r_main_valid | m_tready;

    // Next-state for both entries; skid is only filled while main is stalled
    always_comb begin
        w_main_valid_n = r_main_valid;
        w_main_data_n  = r_main_data;
        w_skid_valid_n = r_skid_valid;
        w_skid_data_n  = r_skid_data;
        if (w_main_free) begin
            if (r_skid_valid) begin
                // s_tready was low, so no input transfer can coincide here
                w_main_valid_n = 1'b1;
                w_main_data_n  = r_skid_data;
                w_skid_valid_n = 1'b0;
            end else if (w_s_xfer) begin
                w_main_valid_n = 1'b1;
                w_main_data_n  = s_tdata;
            end else begin
                w_main_valid_n = 1'b0;
            end
        end else if (w_s_xfer) begin
            w_skid_valid_n = 1'b1;
            w_skid_data_n  = s_tdata;
        end
    end

    // Register both entries and a ready that tracks skid occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_s_tready   <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_n;
            r_main_data  <= w_main_data_n;
            r_skid_valid <= w_skid_valid_n;
            r_skid_data  <= w_skid_data_n;
            r_s_tready   <= ~w_skid_valid_n;
        end
    end

    assign s_tready = r_s_tready;
    assign m_tvalid = r_main_valid;
    assign m_tdata  = r_main_data;

endmodule

// File: rtl/alu_opb_stage.sv
// rtl/alu_opb_stage.sv - operand-B select/extend stage feeding the ALU through a skid buffer
module alu_opb_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          IMM_W   = 16,
    parameter int unsigned INC_VAL = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_b,
    output logic              sel_err
);

    logic [DATA_W-1:0] w_imm_zext;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_op_b;
    logic              w_in_xfer;
    logic              r_sel_err;

    assign w_imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign w_imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_in_xfer  = in_valid & in_ready;

    // Combinational operand-B selection; everything wraps to DATA_W bits
    always_comb begin
        w_op_b = '0;
        case (opb_sel_e'(sel))
            SEL_REGB:  w_op_b = reg_b;
            SEL_INC:   w_op_b = DATA_W'(INC_VAL);
            SEL_BR:    w_op_b = w_imm_sext << BR_SHIFT;
            SEL_SEXT:  w_op_b = w_imm_sext;
            SEL_ZEXT:  w_op_b = w_imm_zext;
            SEL_LUI:   w_op_b = {imm, {(DATA_W-IMM_W){1'b0}}};
            // Narrow immediates read zeros above their top bit
            SEL_SHAMT: w_op_b = {{(DATA_W-SHAMT_W){1'b0}},
                                 w_imm_zext[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]};
            SEL_RSVD:  w_op_b = '0;
            default:   w_op_b = '0;
        endcase
    end

    // Sticky flag for any accepted reserved select; cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_err <= 1'b0;
        end else if (w_in_xfer && (opb_sel_e'(sel) == SEL_RSVD)) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;

    opb_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .s_tdata  (w_op_b),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (op_b)
    );

endmodule

// File: tb/tb_alu_opb_stage.sv
// tb/tb_alu_opb_stage.sv - directed self-checking bench for alu_opb_stage
module tb_alu_opb_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] reg_b;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_b;
    logic        sel_err;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [2:0]  n_sel;
    logic [15:0] n_reg_b;
    logic [7:0]  n_imm;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [15:0] n_op_b;
    logic        n_sel_err;

    int checks;
    int failures;

    alu_opb_stage #(.DATA_W(32), .IMM_W(16), .INC_VAL(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .reg_b(reg_b), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .op_b(op_b), .sel_err(sel_err)
    );

    alu_opb_stage #(.DATA_W(16), .IMM_W(8), .INC_VAL(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .sel(n_sel), .reg_b(n_reg_b), .imm(n_imm), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .op_b(n_op_b), .sel_err(n_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (op_b !== 32'h0) begin failures++; $display("FAIL reset_op_b got=%h exp=0", op_b); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_before_edge got=%b exp=0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_after_edge got=%b exp=1", in_ready); end
        checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL n_in_ready_after_edge got=%b exp=1", n_in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'b010;
        imm       = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL br_out_valid got=%b exp=1", out_valid); end
        checks++; if (op_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL br_op_b got=%h exp=fffffffc", op_b); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL br_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  v_sel [3];
        logic [15:0] v_imm [3];
        logic [31:0] v_exp [3];
        v_sel = '{3'b001, 3'b101, 3'b110};
        v_imm = '{16'h0000, 16'h1234, 16'h07C0};
        v_exp = '{32'd4, 32'h1234_0000, 32'd31};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sel      = v_sel[i];
            imm      = v_imm[i];
            tick();
            checks++; if (out_valid !== 1'b1 || op_b !== v_exp[i]) begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, op_b, v_exp[i]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_select_table();
        logic [2:0]  v_sel [9];
        logic [15:0] v_imm [9];
        logic [31:0] v_reg [9];
        logic [31:0] v_exp [9];
        v_sel = '{3'b000, 3'b011, 3'b011, 3'b100, 3'b010, 3'b010, 3'b101, 3'b110, 3'b110};
        v_imm = '{16'h5555, 16'h8000, 16'h7FFF, 16'h8000, 16'h4000, 16'h8001, 16'hFFFF, 16'hFFFF, 16'h0040};
        v_reg = '{32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        v_exp = '{32'hDEAD_BEEF, 32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_8000, 32'h0001_0000,
                  32'hFFFE_0004, 32'hFFFF_0000, 32'h0000_001F, 32'h0000_0001};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            sel      = v_sel[i];
            imm      = v_imm[i];
            reg_b    = v_reg[i];
            tick();
            checks++; if (out_valid !== 1'b1 || op_b !== v_exp[i]) begin failures++; $display("FAIL sel_table_%0d got=%b/%h exp=1/%h", i, out_valid, op_b, v_exp[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'b000;
        reg_b     = 32'h0000_00A1;
        tick();
        checks++; if (out_valid !== 1'b1 || op_b !== 32'hA1) begin failures++; $display("FAIL stall_c1 got=%b/%h exp=1/a1", out_valid, op_b); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_c1_ready got=%b exp=1", in_ready); end
        reg_b = 32'h0000_00B2;
        tick();
        checks++; if (op_b !== 32'hA1) begin failures++; $display("FAIL stall_c2_hold got=%h exp=a1", op_b); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_c2_ready got=%b exp=0", in_ready); end
        reg_b = 32'h0000_00C3;
        tick();
        checks++; if (out_valid !== 1'b1 || op_b !== 32'hA1) begin failures++; $display("FAIL stall_c3_hold got=%b/%h exp=1/a1", out_valid, op_b); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_c3_ready got=%b exp=0", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || op_b !== 32'hB2) begin failures++; $display("FAIL stall_second got=%b/%h exp=1/b2", out_valid, op_b); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_back got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_no_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_idle_ignored();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 3'b111;
        reg_b     = 32'h1234_5678;
        tick();
        tick();
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL idle_sel_err got=%b exp=0", sel_err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_sel_err();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'b111;
        reg_b     = 32'hCAFE_F00D;
        imm       = 16'hFFFF;
        tick();
        checks++; if (out_valid !== 1'b1 || op_b !== 32'h0) begin failures++; $display("FAIL rsvd_op_b got=%b/%h exp=1/0", out_valid, op_b); end
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL rsvd_sel_err got=%b exp=1", sel_err); end
        sel   = 3'b000;
        reg_b = 32'h0000_0055;
        tick();
        checks++; if (op_b !== 32'h55 || sel_err !== 1'b1) begin failures++; $display("FAIL rsvd_sticky got=%h/%b exp=55/1", op_b, sel_err); end
        in_valid = 1'b0;
        tick();
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL rsvd_sticky_idle got=%b exp=1", sel_err); end
    endtask

    task automatic test_reset_midstall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'b000;
        reg_b     = 32'h0000_0D0D;
        tick();
        reg_b = 32'h0000_0E0E;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL midstall_full got=%b/%b exp=0/1", in_ready, out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midstall_async_valid got=%b exp=0", out_valid); end
        checks++; if (op_b !== 32'h0 || sel_err !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midstall_async_state got=%h/%b/%b exp=0/0/0", op_b, sel_err, in_ready); end
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midstall_stale_%0d got=%b/%h exp=0", i, out_valid, op_b); end
        end
        in_valid = 1'b1;
        sel      = 3'b100;
        imm      = 16'hABCD;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op_b !== 32'h0000_ABCD) begin failures++; $display("FAIL post_reset_xfer got=%b/%h exp=1/0000abcd", out_valid, op_b); end
        tick();
    endtask

    task automatic test_narrow();
        logic [2:0]  v_sel [4];
        logic [7:0]  v_imm [4];
        logic [15:0] v_exp [4];
        v_sel = '{3'b011, 3'b101, 3'b110, 3'b010};
        v_imm = '{8'h80, 8'hAB, 8'hC0, 8'h81};
        v_exp = '{16'hFF80, 16'hAB00, 16'h0003, 16'hFE04};
        n_out_ready = 1'b1;
        n_reg_b     = 16'h0;
        for (int i = 0; i < 4; i++) begin
            n_in_valid = 1'b1;
            n_sel      = v_sel[i];
            n_imm      = v_imm[i];
            tick();
            checks++; if (n_out_valid !== 1'b1 || n_op_b !== v_exp[i]) begin failures++; $display("FAIL narrow_%0d got=%b/%h exp=1/%h", i, n_out_valid, n_op_b, v_exp[i]); end
        end
        n_in_valid = 1'b0;
        tick();
        checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL narrow_drain got=%b exp=0", n_out_valid); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        sel         = 3'b000;
        reg_b       = 32'h0;
        imm         = 16'h0;
        n_in_valid  = 1'b0;
        n_out_ready = 1'b1;
        n_sel       = 3'b000;
        n_reg_b     = 16'h0;
        n_imm       = 8'h0;
        test_reset();
        test_branch();
        test_back_to_back();
        test_select_table();
        test_stall();
        test_idle_ignored();
        test_sel_err();
        test_reset_midstall();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_opb_stage.md
ALU_OPB_STAGE -- requirements
Module: alu_opb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width, legal 16..64.
REQ-002 SHALL have parameter IMM_W, default 16: immediate width, legal 8..DATA_W-2.
REQ-003 SHALL have parameter INC_VAL, default 4: PC-increment constant.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  upstream request valid.
REQ-007 SHALL have port in_ready  out  1  stage can accept.
REQ-008 SHALL have port sel  in  3  operand-B source select.
REQ-009 SHALL have port reg_b  in  DATA_W  register-file B value.
REQ-010 SHALL have port imm  in  IMM_W  instruction immediate.
REQ-011 SHALL have port out_valid  out  1  result valid.
REQ-012 SHALL have port out_ready  in  1  ALU accepts result.
REQ-013 SHALL have port op_b  out  DATA_W  selected operand B.
REQ-014 SHALL have port sel_err  out  1  reserved-select sticky flag.

Function
REQ-015 SHALL compute, for sel: 000 reg_b; 001 INC_VAL zero-extended; 010 sign-extended imm shifted left 2 (branch offset); 011 sign-extended imm; 100 zero-extended imm; 101 imm placed in upper IMM_W bits, lower zeros (LUI); 110 imm[10:6] zero-extended (shamt); 111 reserved, value 0.
REQ-016 SHALL truncate all results to DATA_W bits, discarding bits shifted out (no saturation).
REQ-017 SHALL accept a request on any cycle where in_valid and in_ready are both 1 (transfer).
REQ-018 SHALL deliver a transfer on any cycle where out_valid and out_ready are both 1.
REQ-019 SHALL register the result: latency exactly 1 cycle from input transfer to out_valid when the buffer is empty.
REQ-020 SHALL contain a 2-entry skid buffer; sustained throughput 1 transfer/cycle while out_ready=1.
REQ-021 SHALL drive in_ready from a register: 1 when the skid entry is empty, 0 when both entries occupied.
REQ-022 SHALL, when out_ready=0 with main entry full and a transfer arrives, store it in the skid entry and drop in_ready next cycle.
REQ-023 SHALL, on simultaneous input and output transfer, update the main entry with no bubble and no loss.
REQ-024 SHALL hold op_b stable while out_valid=1 and out_ready=0.
REQ-025 SHALL deliver results in acceptance order; no duplication, no drop.
REQ-026 SHALL set sel_err on any input transfer with sel=111; it remains 1 until reset; the result (0) still propagates.
REQ-027 SHALL ignore sel, reg_b and imm when no input transfer occurs.

Reset
REQ-028 SHALL, while reset_n=0, force out_valid=0, op_b=0, sel_err=0, in_ready=0, both buffer entries empty, independent of clk.
REQ-029 SHALL raise in_ready on the first clk edge after reset_n deasserts.
REQ-030 SHALL discard any buffered result on reset mid-operation; nothing from before reset appears afterwards.

Structure
REQ-031 SHALL take select encodings (SEL_REGB, SEL_INC, SEL_BR, SEL_SEXT, SEL_ZEXT, SEL_LUI, SEL_SHAMT, SEL_RSVD) from shared package cpu_ctrl_pkg.
REQ-032 SHALL place the 2-entry buffer in sub-module opb_skid_buffer, parametrised by DATA_W; the select/extend logic stays combinational in the top.

Verification
REQ-033 SHALL verify: reset, then sel=010, imm=16'hFFFF, out_ready=1 -> next cycle out_valid=1, op_b=32'hFFFF_FFFC.
REQ-034 SHALL verify: back-to-back sel=001, 101 (imm=16'h1234), 110 (imm=16'h07C0) -> op_b 4, 32'h1234_0000, 31 on consecutive cycles, no bubbles.
REQ-035 SHALL verify: out_ready=0 for 3 cycles with in_valid=1 -> two accepted, in_ready=0 from cycle 2, op_b stable; out_ready=1 -> both delivered in order.
REQ-036 SHALL verify: sel=111 transfer -> op_b=0, sel_err=1 persisting through later valid transfers until reset_n=0.
REQ-037 SHALL verify: reset_n=0 asserted mid-stall with two entries held -> out_valid=0 immediately; after release no stale result emerges.
REQ-038 SHALL verify: DATA_W=16, IMM_W=8, sel=011, imm=8'h80 -> op_b=16'hFF80.
